alu_muldiv_seq: RTL and testbench

//  Iterative RV32M multiply/divide unit. Handles the M-extension opcodes that ALUMin does not execute.
//  The core issues a request (opcode + operands) with a start pulse.
//  The unit answers with busy and then a one-cycle done pulse, with the result held afterwards.

---
 rtl/alu_muldiv_seq_pkg.sv | 75 +++++++
 rtl/muldiv_sign_fix.sv | 47 ++++
 rtl/alu_muldiv_seq.sv | 166 ++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq_pkg
//   Shared constants for the iterative RV32M multiply/divide unit.
//   Contents: datapath widths, the ALU opcode encodings (base ALU set plus
//   the M-extension set), the sequencer state encoding and small opcode
//   classification helpers.
// ---------------------------------------------------------------------------
package alu_muldiv_seq_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   // Base ALU opcodes executed by the combinational ALU.
   localparam logic [4:0] OPAND    = 5'd0;
   localparam logic [4:0] OPOR     = 5'd1;
   localparam logic [4:0] OPXOR    = 5'd2;
   localparam logic [4:0] OPADD    = 5'd3;
   localparam logic [4:0] OPSUB    = 5'd4;
   localparam logic [4:0] OPSLT    = 5'd5;
   localparam logic [4:0] OPSLTU   = 5'd6;
   localparam logic [4:0] OPSLL    = 5'd7;
   localparam logic [4:0] OPSRL    = 5'd8;
   localparam logic [4:0] OPSRA    = 5'd9;
   localparam logic [4:0] OPLUI    = 5'd10;
   localparam logic [4:0] OPNULL   = 5'd15;

   // M-extension opcodes handled by the sequential unit.
   localparam logic [4:0] OPMUL    = 5'd16;
   localparam logic [4:0] OPMULH   = 5'd17;
   localparam logic [4:0] OPMULHSU = 5'd18;
   localparam logic [4:0] OPMULHU  = 5'd19;
   localparam logic [4:0] OPDIV    = 5'd20;
   localparam logic [4:0] OPDIVU   = 5'd21;
   localparam logic [4:0] OPREM    = 5'd22;
   localparam logic [4:0] OPREMU   = 5'd23;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic is_m_op(input logic [4:0] op);
      case (op)
         OPMUL, OPMULH, OPMULHSU, OPMULHU,
         OPDIV, OPDIVU, OPREM, OPREMU: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

   function automatic logic is_mul_op(input logic [4:0] op);
      case (op)
         OPMUL, OPMULH, OPMULHSU, OPMULHU: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

   // rs1 is treated as signed for everything except the fully unsigned ops.
   function automatic logic op_a_signed(input logic [4:0] op);
      case (op)
         OPMUL, OPMULH, OPMULHSU, OPDIV, OPREM: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   // rs2 is signed only for the signed x signed ops (MULHSU takes it unsigned).
   function automatic logic op_b_signed(input logic [4:0] op);
      case (op)
         OPMUL, OPMULH, OPDIV, OPREM: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// ---------------------------------------------------------------------------
// muldiv_sign_fix
//   Combinational post-processing of the magnitude accumulator: applies the
//   sign correction, selects the requested half / quotient / remainder and
//   substitutes the architectural divide-by-zero results.
//   Ports:
//     mag_i     in  64  accumulator: product, or {remainder, quotient}
//     op_i      in  5   latched opcode
//     a_neg_i   in  1   rs1 was taken as a negative signed value
//     b_neg_i   in  1   rs2 was taken as a negative signed value
//     b_zero_i  in  1   divisor was zero
//     a_raw_i   in  32  rs1 exactly as latched (remainder of a divide by zero)
//     result_o  out 32  final result
// ---------------------------------------------------------------------------
module muldiv_sign_fix
   import alu_muldiv_seq_pkg::*;
(
   input  logic [2*XLEN-1:0] mag_i,
   input  logic [4:0]        op_i,
   input  logic              a_neg_i,
   input  logic              b_neg_i,
   input  logic              b_zero_i,
   input  logic [XLEN-1:0]   a_raw_i,
   output logic [XLEN-1:0]   result_o
);

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   rem;

   always_comb begin
      prod = (a_neg_i ^ b_neg_i) ? -mag_i : mag_i;
      quot = (a_neg_i ^ b_neg_i) ? -mag_i[XLEN-1:0] : mag_i[XLEN-1:0];
      // Remainder follows the dividend's sign. 0x80000000 / -1 falls out
      // naturally: magnitude quotient 0x80000000 with equal signs, rem 0.
      rem  = a_neg_i ? -mag_i[2*XLEN-1:XLEN] : mag_i[2*XLEN-1:XLEN];

      case (op_i)
         OPMUL:                      result_o = prod[XLEN-1:0];
         OPMULH, OPMULHSU, OPMULHU:  result_o = prod[2*XLEN-1:XLEN];
         OPDIV, OPDIVU:              result_o = b_zero_i ? '1 : quot;
         OPREM, OPREMU:              result_o = b_zero_i ? a_raw_i : rem;
         default:                    result_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//   Iterative RV32M multiply/divide unit. A request is accepted on iStart in
//   IDLE or DONE, runs 32 iterations on magnitudes in a shared 64-bit
//   accumulator, one sign-fix cycle, then pulses oDone with the result held.
//   Ports:
//     iCLK      in  1     clock, rising edge
//     iRST      in  1     asynchronous active-low reset
//     iStart    in  1     request strobe
//     iControl  in  5     opcode (M-extension opcodes only are accepted)
//     iA        in  32    rs1
//     iB        in  32    rs2
//     oBusy     out 1     operation in flight (CALC and FIX)
//     oDone     out 1     one-cycle result-valid pulse
//     oResult   out 32    result, held until overwritten by the next one
// ---------------------------------------------------------------------------
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
(
   input  logic            iCLK,
   input  logic            iRST,
   input  logic            iStart,
   input  logic [4:0]      iControl,
   input  logic [XLEN-1:0] iA,
   input  logic [XLEN-1:0] iB,
   output logic            oBusy,
   output logic            oDone,
   output logic [XLEN-1:0] oResult
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   state_t              state_q,  state_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [2*XLEN-1:0]   acc_q,    acc_d;
   logic [4:0]          op_q,     op_d;
   logic [XLEN-1:0]     a_q,      a_d;
   logic [XLEN-1:0]     mag_b_q,  mag_b_d;
   logic                a_neg_q,  a_neg_d;
   logic                b_neg_q,  b_neg_d;
   logic                busy_q,   busy_d;
   logic                done_q,   done_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                accept;
   logic [XLEN-1:0]     mag_a_in;
   logic [XLEN:0]       mul_sum;
   logic [XLEN:0]       div_partial;
   logic                div_ge;
   logic [XLEN-1:0]     div_diff;
   logic [XLEN-1:0]     fix_result;

   muldiv_sign_fix u_sign_fix (
      .mag_i    (acc_q),
      .op_i     (op_q),
      .a_neg_i  (a_neg_q),
      .b_neg_i  (b_neg_q),
      .b_zero_i (mag_b_q == '0),
      .a_raw_i  (a_q),
      .result_o (fix_result)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      op_d     = op_q;
      a_d      = a_q;
      mag_b_d  = mag_b_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;

      accept   = iStart && is_m_op(iControl) &&
                 ((state_q == ST_IDLE) || (state_q == ST_DONE));
      mag_a_in = '0;

      // Shift-add step: add multiplicand into the high half when the current
      // multiplier bit (acc[0]) is set, then shift the whole pair right.
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                 (acc_q[0] ? {1'b0, mag_b_q} : {(XLEN+1){1'b0}});

      // Restoring step: the partial remainder after the left shift needs one
      // extra bit. When it is >= divisor the difference fits in XLEN bits, so
      // only the low XLEN bits of the subtraction are kept.
      div_partial = acc_q[2*XLEN-1:XLEN-1];
      div_ge      = div_partial >= {1'b0, mag_b_q};
      div_diff    = div_partial[XLEN-1:0] - mag_b_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept) begin
               op_d     = iControl;
               a_d      = iA;
               a_neg_d  = op_a_signed(iControl) & iA[XLEN-1];
               b_neg_d  = op_b_signed(iControl) & iB[XLEN-1];
               mag_a_in = a_neg_d ? -iA : iA;
               mag_b_d  = b_neg_d ? -iB : iB;
               acc_d    = {{XLEN{1'b0}}, mag_a_in};
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = ST_CALC;
            end
         end
         ST_CALC: begin
            if (is_mul_op(op_q)) begin
               acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end else if (div_ge) begin
               acc_d = {div_diff, acc_q[XLEN-2:0], 1'b1};
            end else begin
               acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            result_d = fix_result;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         mag_b_q  <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         op_q     <= op_d;
         a_q      <= a_d;
         mag_b_q  <= mag_b_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign oBusy   = busy_q;
   assign oDone   = done_q;
   assign oResult = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;
   import alu_muldiv_seq_pkg::*;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b0;
   logic        iStart = 1'b0;
   logic [4:0]  iControl = 5'd0;
   logic [31:0] iA = 32'd0;
   logic [31:0] iB = 32'd0;
   logic        oBusy;
   logic        oDone;
   logic [31:0] oResult;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] sb[$];

   alu_muldiv_seq dut (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .iStart   (iStart),
      .iControl (iControl),
      .iA       (iA),
      .iB       (iB),
      .oBusy    (oBusy),
      .oDone    (oDone),
      .oResult  (oResult)
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end else begin
         $display("ok   %s: 0x%08h (t=%0t)", name, act, $time);
      end
   endtask

   // Reference model straight from the RV32M rules, using wide arithmetic.
   function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sp;
      logic [63:0] up;
      int          sa, sbv;
      sa  = $signed(a);
      sbv = $signed(b);
      case (op)
         OPMUL:    begin sp = longint'(sa) * longint'(sbv); return sp[31:0]; end
         OPMULH:   begin sp = longint'(sa) * longint'(sbv); return sp[63:32]; end
         OPMULHSU: begin sp = longint'(sa) * longint'({32'd0, b}); return sp[63:32]; end
         OPMULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
         OPDIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sbv);
         end
         OPREM: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sbv);
         end
         OPDIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         OPREMU:   return (b == 32'd0) ? a : a % b;
         default:  return 32'd0;
      endcase
   endfunction

   // Monitor: every oDone pops one expectation and compares.
   task automatic monitor_loop();
      forever begin
         @(negedge iCLK);
         if (iRST && oDone) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_done: got oDone=1 with result 0x%08h, expected no pending request", oResult);
            end else begin
               check("result", oResult, sb.pop_front());
            end
         end
      end
   endtask

   // Waits for oDone after a start edge; returns edges to done and busy cycles.
   task automatic wait_done(output int edges, output int busy_cnt, output bit seen);
      busy_cnt = oBusy ? 1 : 0;
      edges    = 0;
      seen     = 1'b0;
      while (!seen && edges < 45) begin
         @(posedge iCLK);
         #1;
         iA = $urandom;
         iB = $urandom;
         edges++;
         if (oDone) seen = 1'b1;
         else if (oBusy) busy_cnt++;
      end
   endtask

   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int edges, busy_cnt;
      bit seen;
      @(negedge iCLK);
      iControl = op;
      iA       = a;
      iB       = b;
      iStart   = 1'b1;
      sb.push_back(exp);
      @(posedge iCLK);
      #1;
      iStart   = 1'b0;
      iControl = 5'($urandom);
      wait_done(edges, busy_cnt, seen);
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         check("latency", 32'(edges), 32'd33);
         check("busy_cycles", 32'(busy_cnt), 32'd33);
         check("busy_at_done", {31'd0, oBusy}, 32'd0);
      end
   endtask

   logic [4:0]  d_op [12] = '{OPMUL, OPMULH, OPMULHU, OPMULHSU, OPDIV, OPREM,
                              OPDIVU, OPREMU, OPDIV, OPREMU, OPDIV, OPREM};
   logic [31:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd10,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
   logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd2, 32'd3,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] d_exp[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd1,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
   logic [4:0]  m_ops[8] = '{OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU};
   logic [31:0] corner[6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};

   initial begin
      int edges, busy_cnt;
      bit seen;
      int busy_seen;
      logic [31:0] ra, rb;
      logic [4:0]  rop;

      fork
         monitor_loop();
      join_none

      // Reset state
      repeat (3) @(negedge iCLK);
      check("reset_busy", {31'd0, oBusy}, 32'd0);
      check("reset_done", {31'd0, oDone}, 32'd0);
      check("reset_result", oResult, 32'd0);
      iRST = 1'b1;

      // Directed cases; consecutive runs restart from DONE (back-to-back)
      for (int i = 0; i < 12; i++) begin
         run_op(d_op[i], d_a[i], d_b[i], d_exp[i]);
      end

      // Start pulse while busy is ignored
      @(negedge iCLK);
      iControl = OPMUL; iA = 32'd1234; iB = 32'd5678; iStart = 1'b1;
      sb.push_back(32'd7006652);
      @(posedge iCLK); #1; iStart = 1'b0;
      repeat (4) @(posedge iCLK);
      @(negedge iCLK);
      iControl = OPDIV; iA = 32'd100; iB = 32'd7; iStart = 1'b1;
      @(posedge iCLK); #1; iStart = 1'b0;
      wait_done(edges, busy_cnt, seen);
      check("busy_start_ignored_done", {31'd0, seen}, 32'd1);

      // Asynchronous reset mid-operation
      @(negedge iCLK);
      iControl = OPMUL; iA = 32'd3; iB = 32'd3; iStart = 1'b1;
      sb.push_back(32'd9);
      @(posedge iCLK); #1; iStart = 1'b0;
      repeat (9) @(posedge iCLK);
      #2;
      iRST = 1'b0;
      #1;
      check("async_rst_busy", {31'd0, oBusy}, 32'd0);
      check("async_rst_result", oResult, 32'd0);
      check("async_rst_done", {31'd0, oDone}, 32'd0);
      sb.delete();
      @(negedge iCLK);
      iRST = 1'b1;
      run_op(OPDIV, 32'd9, 32'd3, 32'd3);

      // Non-M opcode is ignored
      @(negedge iCLK);
      iControl = OPADD; iA = 32'd1; iB = 32'd2; iStart = 1'b1;
      @(posedge iCLK); #1; iStart = 1'b0;
      busy_seen = 0;
      repeat (40) begin
         @(posedge iCLK); #1;
         if (oBusy || oDone) busy_seen++;
      end
      check("nonm_no_busy", 32'(busy_seen), 32'd0);
      check("nonm_result_held", oResult, 32'd3);

      // Randomized traffic against the reference model
      for (int k = 0; k < 120; k++) begin
         rop = m_ops[$urandom_range(0, 7)];
         ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge iCLK);
         run_op(rop, ra, rb, ref_model(rop, ra, rb));
      end

      repeat (3) @(negedge iCLK);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
